// File: rtl/mini_alu_pkg.sv
// Shared definitions for the 4-bit registered ALU: datapath width and the
// op encodings seen on {SB,SA}.
package mini_alu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

endpackage

// File: rtl/mini_alu_if.sv
// Bit-level operand/result bundle of the ALU. The master side drives op
// select, operands and carry-in; the slave side (the ALU) returns the
// registered result, carry-out and overflow flag.
interface mini_alu_if;

  logic SB, SA;
  logic A3, A2, A1, A0;
  logic B3, B2, B1, B0;
  logic Cin;
  logic C3, C2, C1, C0;
  logic Cout;
  logic SC;

  modport master (
    output SB, SA, A3, A2, A1, A0, B3, B2, B1, B0, Cin,
    input  C3, C2, C1, C0, Cout, SC
  );

  modport slave (
    input  SB, SA, A3, A2, A1, A0, B3, B2, B1, B0, Cin,
    output C3, C2, C1, C0, Cout, SC
  );

endinterface

// File: rtl/mini_alu_adder4.sv
// Combinational ripple-carry adder built from full-adder bit slices.
// Exposes both the final carry and the carry into the MSB so the caller
// can form the two's-complement overflow flag.
module mini_alu_adder4
  import mini_alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             cin,
  output logic [ALU_W-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [ALU_W:0] carry;

  assign carry[0] = cin;

  // One full-adder slice per bit, carry rippling from LSB to MSB
  for (genvar i = 0; i < ALU_W; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout  = carry[ALU_W];
  assign c_msb = carry[ALU_W-1];

endmodule

// File: rtl/mini_alu.sv
// 4-bit registered ALU: ADD/SUB share one ripple adder (SUB feeds ~B),
// AND/XOR are plain bitwise ops. All outputs are registered, one clock
// of latency, with a synchronous active-high reset.
module mini_alu
  import mini_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mini_alu_if.slave  bus
);

  op_e              op;
  logic [ALU_W-1:0] a;
  logic [ALU_W-1:0] b;
  logic [ALU_W-1:0] b_eff;
  logic [ALU_W-1:0] sum;
  logic             add_cout;
  logic             add_c_msb;

  logic [ALU_W-1:0] res_d;
  logic             cout_d;
  logic             sc_d;

  logic [ALU_W-1:0] res_q;
  logic             cout_q;
  logic             sc_q;

  assign a = {bus.A3, bus.A2, bus.A1, bus.A0};
  assign b = {bus.B3, bus.B2, bus.B1, bus.B0};

  // Subtraction is A + ~B + Cin, so only the B operand changes per op
  always_comb begin
    op    = op_e'({bus.SB, bus.SA});
    b_eff = (op == OP_SUB) ? ~b : b;
  end

  mini_alu_adder4 u_adder (
    .a     (a),
    .b     (b_eff),
    .cin   (bus.Cin),
    .sum   (sum),
    .cout  (add_cout),
    .c_msb (add_c_msb)
  );

  // Result mux: arithmetic ops carry flags, logic ops force them low
  always_comb begin
    res_d  = '0;
    cout_d = 1'b0;
    sc_d   = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        res_d  = sum;
        cout_d = add_cout;
        sc_d   = add_c_msb ^ add_cout;
      end
      OP_AND: res_d = a & b;
      OP_XOR: res_d = a ^ b;
      default: res_d = '0;
    endcase
  end

  // Output registers; reset wins over every input
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      cout_q <= 1'b0;
      sc_q   <= 1'b0;
    end else begin
      res_q  <= res_d;
      cout_q <= cout_d;
      sc_q   <= sc_d;
    end
  end

  assign bus.C3   = res_q[3];
  assign bus.C2   = res_q[2];
  assign bus.C1   = res_q[1];
  assign bus.C0   = res_q[0];
  assign bus.Cout = cout_q;
  assign bus.SC   = sc_q;

endmodule

// File: tb/tb_mini_alu.sv
// Self-checking bench for mini_alu: a table of directed vectors applied
// one per cycle, a latency/hold sequence, and an exhaustive sweep of all
// 2048 input combinations against an independent reference model.
module tb_mini_alu;
  import mini_alu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mini_alu_if bus ();

  mini_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] exp_c;
    logic       exp_cout;
    logic       exp_sc;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  // Reference model written directly from the arithmetic definitions
  function automatic logic [5:0] model(input logic [1:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic cin);
    logic [4:0] s;
    logic [3:0] c;
    logic       co;
    logic       sc;
    s  = 5'd0;
    c  = 4'd0;
    co = 1'b0;
    sc = 1'b0;
    case (op)
      2'b00: begin
        s  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        c  = s[3:0];
        co = s[4];
        sc = (a[3] == b[3]) && (c[3] != a[3]);
      end
      2'b01: begin
        s  = {1'b0, a} + {1'b0, ~b} + {4'd0, cin};
        c  = s[3:0];
        co = s[4];
        sc = (a[3] != b[3]) && (c[3] != a[3]);
      end
      2'b10: c = a & b;
      default: c = a ^ b;
    endcase
    return {c, co, sc};
  endfunction

  // Drive one set of inputs (called away from the rising edge)
  task automatic applyStimulus(input logic r, input logic [1:0] op, input logic [3:0] a,
                               input logic [3:0] b, input logic cin);
    rst     = r;
    bus.SB  = op[1];
    bus.SA  = op[0];
    bus.A3  = a[3];
    bus.A2  = a[2];
    bus.A1  = a[1];
    bus.A0  = a[0];
    bus.B3  = b[3];
    bus.B2  = b[2];
    bus.B1  = b[1];
    bus.B0  = b[0];
    bus.Cin = cin;
  endtask

  // Compare the registered outputs against the expected triple
  task automatic checkOutput(input string name, input logic [3:0] exp_c,
                             input logic exp_cout, input logic exp_sc);
    logic [3:0] got_c;
    got_c = {bus.C3, bus.C2, bus.C1, bus.C0};
    checks++;
    if (got_c !== exp_c || bus.Cout !== exp_cout || bus.SC !== exp_sc) begin
      failures++;
      $display("[TB] FAIL %s: got C=%b Cout=%b SC=%b, expected C=%b Cout=%b SC=%b",
               name, got_c, bus.Cout, bus.SC, exp_c, exp_cout, exp_sc);
    end
  endtask

  initial begin
    logic [5:0]  exp;
    logic [10:0] v;
    logic [3:0]  ea;
    logic [3:0]  eb;
    checks   = 0;
    failures = 0;

    //              name        rst   op     a      b      cin   C      Cout  SC
    vecs[0]  = '{"rst_hold0", 1'b1, 2'b00, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{"rst_hold1", 1'b1, 2'b00, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0};
    vecs[2]  = '{"post_rst",  1'b0, 2'b00, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[3]  = '{"add_ovf",   1'b0, 2'b00, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
    vecs[4]  = '{"add_wrap",  1'b0, 2'b00, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[5]  = '{"add_cin",   1'b0, 2'b00, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[6]  = '{"sub_neg",   1'b0, 2'b01, 4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0};
    vecs[7]  = '{"sub_ovf",   1'b0, 2'b01, 4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 1'b1};
    vecs[8]  = '{"sub_eq",    1'b0, 2'b01, 4'h5, 4'h5, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[9]  = '{"sub_borrow",1'b0, 2'b01, 4'h5, 4'h5, 1'b0, 4'hF, 1'b0, 1'b0};
    vecs[10] = '{"and",       1'b0, 2'b10, 4'hC, 4'hA, 1'b1, 4'h8, 1'b0, 1'b0};
    vecs[11] = '{"xor",       1'b0, 2'b11, 4'hC, 4'hA, 1'b1, 4'h6, 1'b0, 1'b0};
    vecs[12] = '{"b2b_add",   1'b0, 2'b00, 4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0};
    vecs[13] = '{"b2b_sub",   1'b0, 2'b01, 4'h2, 4'h3, 1'b1, 4'hF, 1'b0, 1'b0};
    vecs[14] = '{"mid_rst",   1'b1, 2'b11, 4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0};
    vecs[15] = '{"resume_and",1'b0, 2'b10, 4'hF, 4'h6, 1'b1, 4'h6, 1'b0, 1'b0};
    vecs[16] = '{"b2b_xor",   1'b0, 2'b11, 4'h5, 4'h3, 1'b0, 4'h6, 1'b0, 1'b0};
    vecs[17] = '{"add_negovf",1'b0, 2'b00, 4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};

    applyStimulus(1'b1, 2'b00, 4'h0, 4'h0, 1'b0);
    @(negedge clk);

    // Directed table, one vector per cycle, checked just after the edge
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      @(posedge clk);
      #1;
      checkOutput(vecs[i].name, vecs[i].exp_c, vecs[i].exp_cout, vecs[i].exp_sc);
    end

    // Outputs must hold the previous result while new inputs settle
    applyStimulus(1'b0, 2'b00, 4'h2, 4'h2, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("hold_base", 4'h4, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b11, 4'h9, 4'h6, 1'b0);
    #2;
    checkOutput("hold_mid", 4'h4, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("hold_next", 4'hF, 1'b0, 1'b0);

    // Exhaustive sweep of {SB,SA,A3,B3,A2,B2,A1,B1,A0,B0,Cin}
    for (int n = 0; n < 2048; n++) begin
      v  = n[10:0];
      ea = {v[8], v[6], v[4], v[2]};
      eb = {v[7], v[5], v[3], v[1]};
      applyStimulus(1'b0, v[10:9], ea, eb, v[0]);
      exp = model(v[10:9], ea, eb, v[0]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("exh_%0d", n), exp[5:2], exp[1], exp[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
